// File: rtl/alu_dispatch.sv
// Issue stage ahead of the 4-bit ALU units: buffers {a, b, op} commands in a FIFO,
// issues one per cycle to registered operands, and tracks the units' one-cycle latency.
module alu_dispatch #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  input  logic [M-1:0]             in_op,
  input  logic                     hold,
  input  logic                     flush,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [M-2:0]             alu_instruction,
  output logic                     res_valid,
  output logic                     res_unit,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]   a_mem  [DEPTH];
  logic [N-1:0]   b_mem  [DEPTH];
  logic [M-1:0]   op_mem [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   alu_a_q, alu_a_d;
  logic [N-1:0]   alu_b_q, alu_b_d;
  logic [M-2:0]   alu_ins_q, alu_ins_d;
  logic           issue_v_q, issue_v_d;
  logic           issue_unit_q, issue_unit_d;
  logic           res_valid_q, res_valid_d;
  logic           res_unit_q, res_unit_d;
  logic           push, pop;

  assign in_ready = (count_q != CW'(DEPTH));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ins_d    = alu_ins_q;
    issue_unit_d = issue_unit_q;
    // Flush wins over both sides of the FIFO.
    push         = in_valid && in_ready && !flush;
    pop          = (count_q != '0) && !hold && !flush;
    issue_v_d    = pop;
    res_valid_d  = issue_v_q && !flush;
    res_unit_d   = issue_unit_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + AW'(1);
        alu_a_d      = a_mem[rd_ptr_q];
        alu_b_d      = b_mem[rd_ptr_q];
        alu_ins_d    = op_mem[rd_ptr_q][M-2:0];
        issue_unit_d = op_mem[rd_ptr_q][M-1];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q]  <= in_a;
      b_mem[wr_ptr_q]  <= in_b;
      op_mem[wr_ptr_q] <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ins_q    <= '0;
      issue_v_q    <= 1'b0;
      issue_unit_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_unit_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ins_q    <= alu_ins_d;
      issue_v_q    <= issue_v_d;
      issue_unit_q <= issue_unit_d;
      res_valid_q  <= res_valid_d;
      res_unit_q   <= res_unit_d;
    end
  end

  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_instruction = alu_ins_q;
  assign res_valid       = res_valid_q;
  assign res_unit        = res_unit_q;
  assign occupancy       = count_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_alu_dispatch;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] in_op = '0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_instruction;
  logic       res_valid;
  logic       res_unit;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_dispatch #(.N(4), .M(4), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_op           (in_op),
    .hold            (hold),
    .flush           (flush),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_instruction (alu_instruction),
    .res_valid       (res_valid),
    .res_unit        (res_unit),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in for the logical unit: AND for 000, XNOR for 111, registered one cycle.
  function automatic logic [3:0] lu_fn(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] ins);
    return (ins == 3'b111) ? ~(a ^ b) : (a & b);
  endfunction

  logic [3:0] lu_q;
  always @(posedge clk) lu_q <= lu_fn(alu_a, alu_b, alu_instruction);

  // Reference model: command queue, issue stage, result stage.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
  } cmd_t;

  cmd_t mq[$];
  bit   m_iv, m_rv;
  cmd_t m_is, m_rs;
  logic [3:0] m_a, m_b;
  logic [2:0] m_ins;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_iv = 0; m_rv = 0; m_is = '0; m_rs = '0;
      m_a = '0; m_b = '0; m_ins = '0;
    end else begin
      automatic int sz = mq.size();
      m_rv = m_iv && !flush;
      m_rs = m_is;
      if (flush) begin
        mq.delete();
        m_iv = 0;
      end else begin
        if (sz > 0 && !hold) begin
          m_is  = mq.pop_front();
          m_a   = m_is.a;
          m_b   = m_is.b;
          m_ins = m_is.op[2:0];
          m_iv  = 1;
        end else begin
          m_iv = 0;
        end
        if (in_valid && sz < int'(DEPTH)) mq.push_back('{a: in_a, b: in_b, op: in_op});
      end
    end
  end

  bit ru_log[$];
  int run = 0;
  int max_run = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != int'(DEPTH)));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_instruction", 32'(alu_instruction), 32'(m_ins));
      if (m_rv) begin
        chk("res_unit", 32'(res_unit), 32'(m_rs.op[3]));
        if (m_rs.op[2:0] == 3'b000 || m_rs.op[2:0] == 3'b111)
          chk("logic_unit_out", 32'(lu_q), 32'(lu_fn(m_rs.a, m_rs.b, m_rs.op[2:0])));
      end
      if (res_valid) begin
        ru_log.push_back(res_unit);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op;
  endtask

  task automatic edge_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] ops2 [4];
  logic [2:0] ins2 [4];
  logic [3:0] ops4 [4];

  initial begin
    ops2[0] = 4'b0000; ops2[1] = 4'b0001; ops2[2] = 4'b0010; ops2[3] = 4'b0111;
    ins2[0] = 3'b000;  ins2[1] = 3'b001;  ins2[2] = 3'b010;  ins2[3] = 3'b111;
    ops4[0] = 4'b1001; ops4[1] = 4'b0001; ops4[2] = 4'b1001; ops4[3] = 4'b0001;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single command: C AND A = 8
    drive(1'b1, 4'hC, 4'hA, 4'b0000);
    edge_wait(1);
    chk("t1_occ_after_push", 32'(occupancy), 1);
    chk("t1_no_bypass", 32'(alu_a), 0);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    edge_wait(1);
    chk("t1_alu_a", 32'(alu_a), 32'hC);
    chk("t1_alu_b", 32'(alu_b), 32'hA);
    chk("t1_alu_ins", 32'(alu_instruction), 0);
    chk("t1_res_valid_early", 32'(res_valid), 0);
    edge_wait(1);
    chk("t1_res_valid", 32'(res_valid), 1);
    chk("t1_res_unit", 32'(res_unit), 0);
    chk("t1_lu_out", 32'(lu_q), 32'h8);
    edge_wait(1);
    chk("t1_res_valid_once", 32'(res_valid), 0);

    // Fill to full under hold, then drain
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1; in_a = 4'(i + 1); in_b = 4'(9 - i); in_op = ops2[i];
    end
    edge_wait(1);
    chk("t2_occ_full", 32'(occupancy), 4);
    chk("t2_in_ready_full", 32'(in_ready), 0);
    drive(1'b1, 4'hF, 4'hF, 4'b0011);
    edge_wait(1);
    chk("t2_fifth_dropped", 32'(occupancy), 4);
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge_wait(1);
      chk("t2_issue_order", 32'(alu_instruction), 32'(ins2[k]));
      chk("t2_res_valid_pipe", 32'(res_valid), 32'(k > 0));
    end
    edge_wait(3);

    // Streaming, 8 back-to-back commands
    ru_log.delete(); max_run = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) drive(1'b1, 4'h5, 4'h5, 4'b0111);
      else        drive(1'b1, 4'(i), 4'(15 - i), {1'(i), 3'b000});
      edge_wait(1);
      chk("t3_occ_le1", 32'(occupancy <= 3'd1), 1);
    end
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    edge_wait(4);
    chk("t3_result_count", 32'(ru_log.size()), 8);
    chk("t3_consecutive", 32'(max_run), 8);

    // Unit select alternation
    ru_log.delete(); max_run = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 2), 4'h3, ops4[i]);
    drive(1'b0, 4'h0, 4'h0, 4'h0);
    edge_wait(5);
    chk("t4_result_count", 32'(ru_log.size()), 4);
    if (ru_log.size() == 4) begin
      chk("t4_unit0", 32'(ru_log[0]), 1);
      chk("t4_unit1", 32'(ru_log[1]), 0);
      chk("t4_unit2", 32'(ru_log[2]), 1);
      chk("t4_unit3", 32'(ru_log[3]), 0);
    end
    chk("t4_consecutive", 32'(max_run), 4);

    // Flush with 3 queued and 1 in flight
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1; in_a = 4'(i + 8); in_b = 4'h1; in_op = 4'b0000;
    end
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b0;
    edge_wait(1);
    chk("t5_occ_before", 32'(occupancy), 3);
    @(negedge clk);
    flush = 1'b1; hold = 1'b1; in_valid = 1'b1; in_a = 4'hE;
    edge_wait(1);
    chk("t5_occ_flushed", 32'(occupancy), 0);
    chk("t5_res_valid_flushed", 32'(res_valid), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    ru_log.delete();
    edge_wait(4);
    chk("t5_no_stale_results", 32'(ru_log.size()), 0);

    // Async reset mid-stream
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      in_valid = 1'b1; in_a = 4'(i + 3); in_b = 4'h6; in_op = 4'b1000;
    end
    @(negedge clk);
    in_valid = 1'b0; hold = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_alu_a", 32'(alu_a), 0);
    chk("t6_alu_b", 32'(alu_b), 0);
    chk("t6_alu_ins", 32'(alu_instruction), 0);
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_res_unit", 32'(res_unit), 0);
    chk("t6_occupancy", 32'(occupancy), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    edge_wait(1);
    @(negedge clk);
    rst_n = 1'b1; hold = 1'b0;
    ru_log.delete();
    edge_wait(1);
    chk("t6_in_ready_after", 32'(in_ready), 1);
    edge_wait(3);
    chk("t6_no_stale_results", 32'(ru_log.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
